// File: rtl/md_unit_pkg.sv
// Shared mul/div encodings for decoder, stall logic and md_unit.
// FSM state type and op classification helpers.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mul(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit: fixed-latency mult/div,
// MTHI/MTLO writes, cancel on exception request.
import md_unit_pkg::*;

module md_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        issue;
  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign issue = start & ~req & ~busy;

  // Sign-extend only for signed mult so one
  // 64-bit multiply serves both flavours.
  always_comb begin
    sgn_mul = (op_q == MD_MULT);
    sgn_div = (op_q == MD_DIV);
    mul_a   = {{32{sgn_mul & a_q[31]}}, a_q};
    mul_b   = {{32{sgn_mul & b_q[31]}}, b_q};
    prod    = mul_a * mul_b;
    abs_a   = (sgn_div && a_q[31]) ? -a_q : a_q;
    abs_b   = (sgn_div && b_q[31]) ? -b_q : b_q;
    dvs     = (b_q == 32'd0) ? 32'd1 : abs_b;
    uq      = abs_a / dvs;
    ur      = abs_a % dvs;
    quo     = (sgn_div && (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem     = (sgn_div && a_q[31]) ? -ur : ur;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      op_q  <= MD_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            unique case (1'b1)
              is_mul(md_op): begin
                state <= S_RUN;
                busy  <= 1'b1;
                cnt   <= 4'(MULT_CYC);
                op_q  <= md_op;
                a_q   <= a;
                b_q   <= b;
              end
              is_div(md_op): begin
                state <= S_RUN;
                busy  <= 1'b1;
                cnt   <= 4'(DIV_CYC);
                op_q  <= md_op;
                a_q   <= a;
                b_q   <= b;
              end
              (md_op == MD_MTHI): hi <= a;
              (md_op == MD_MTLO): lo <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (is_mul(op_q)) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases
// plus random ops against a 64-bit arithmetic model.
module tb_md_unit;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk;
  int n_pass;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .a    (a),
    .b    (b),
    .req  (req),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: plain 64-bit integer arithmetic.
  task automatic model(
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx;
    longint sy;
    longint r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      3'd1: begin
        r = sx * sy;
        p = r;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: begin
        p = {32'd0, x} * {32'd0, y};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd3: if (y != 0) begin
        r = sx / sy;
        p = r;
        m_lo = p[31:0];
        r = sx % sy;
        p = r;
        m_hi = p[31:0];
      end
      3'd4: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic issue(
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        rq
  );
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    req   = rq;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    req   = 1'b0;
  endtask

  task automatic count_busy(
    input string tag,
    input int    exp
  );
    int n;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  task automatic run_op(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        rq
  );
    int cyc;
    issue(op, x, y, rq);
    cyc = 0;
    if (!rq && (op >= 3'd1 && op <= 3'd4))
      cyc = (op <= 3'd2) ? MULT_CYC : DIV_CYC;
    if (!rq) model(op, x, y);
    count_busy({tag, "_busy"}, cyc);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_hi   = 0;
    m_lo   = 0;
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd0;
    a      = 0;
    b      = 0;
    req    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_hi_k", hi, 32'hFFFFFFFF);
    check("mult_lo_k", lo, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi_k", hi, 32'hFFFFFFFE);
    check("multu_lo_k", lo, 32'h00000001);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_k", lo, 32'hFFFFFFFD);
    check("div_hi_k", hi, 32'hFFFFFFFF);
    run_op("divu0", 3'd4, 32'd7, 32'd0, 1'b0);
    check("divu0_lo_k", lo, 32'hFFFFFFFD);
    run_op("divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("divovf_lo_k", lo, 32'h80000000);
    check("divovf_hi_k", hi, 32'd0);
    run_op("mthi", 3'd5, 32'h12345678, 32'd0, 1'b0);
    check("mthi_k", hi, 32'h12345678);
    run_op("mtlo_req", 3'd6, 32'hDEADBEEF, 32'd0, 1'b1);
    run_op("mult_req", 3'd1, 32'd9, 32'd9, 1'b1);

    // MULT with a DIV attempt while busy, then req.
    issue(3'd1, 32'd1000, 32'hFFFFFFF0, 1'b0);
    model(3'd1, 32'd1000, 32'hFFFFFFF0);
    for (int i = 1; i <= MULT_CYC; i++) begin
      check("ovl_busy", 32'(busy), 32'd1);
      start = (i == 2 || i == 3);
      md_op = (i == 2 || i == 3) ? 3'd3 : 3'd0;
      a     = 32'd77;
      b     = 32'd5;
      req   = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    req   = 1'b0;
    md_op = 3'd0;
    check("ovl_done", 32'(busy), 32'd0);
    check("ovl_hi", hi, m_hi);
    check("ovl_lo", lo, m_lo);
    @(negedge clk);
    check("ovl_nodiv", 32'(busy), 32'd0);

    // Reset in the middle of a DIV.
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("rr_busy4", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi  = 0;
    m_lo  = 0;
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_hi", hi, 32'd0);
    check("rr_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("rr_late_hi", hi, 32'd0);
    check("rr_late_lo", lo, 32'd0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic        rq;
      op = 3'($urandom_range(0, 6));
      x  = $urandom;
      y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($signed(y) >>> 24);
      rq = ($urandom_range(0, 5) == 0);
      run_op("rnd", op, x, y, rq);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
